// File: rtl/alu_stack_ctrl_pkg.sv
// Shared definitions for the RPN stack sequencer and its alu: opcodes, command kinds, error codes, FSM states.
// Binary opcodes occupy 5'h00..5'h0F, unary 5'h10..5'h12, everything above is illegal.
package alu_stack_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_MUL  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SRA  = 5'h08;
    localparam logic [4:0] OP_MIN  = 5'h09;
    localparam logic [4:0] OP_MAX  = 5'h0A;
    localparam logic [4:0] OP_EQ   = 5'h0B;
    localparam logic [4:0] OP_NE   = 5'h0C;
    localparam logic [4:0] OP_GE   = 5'h0D;
    localparam logic [4:0] OP_GT   = 5'h0E;
    localparam logic [4:0] OP_LT   = 5'h0F;
    localparam logic [4:0] OP_NEG  = 5'h10;
    localparam logic [4:0] OP_BNOT = 5'h11;
    localparam logic [4:0] OP_ABS  = 5'h12;

    localparam logic [1:0] K_PUSH  = 2'b00;
    localparam logic [1:0] K_OP    = 2'b01;
    localparam logic [1:0] K_POP   = 2'b10;
    localparam logic [1:0] K_CLEAR = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    function automatic logic op_is_unary(input logic [4:0] op);
        return (op >= OP_NEG) && (op <= OP_ABS);
    endfunction

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_ABS;
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit combinational alu driven by the stack sequencer.
// Latency: zero cycles. Backpressure: none, pure function of a/b/f.
module alu
    import alu_stack_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   f,
    output logic [W-1:0] s
);

    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [3:0]          sh;

    assign sa = a;
    assign sb = b;
    assign sh = b[3:0];

    always_comb begin
        s = '0;
        case (f)
            OP_ADD:  s = a + b;
            OP_SUB:  s = a - b;
            OP_MUL:  s = a * b;
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            OP_XOR:  s = a ^ b;
            OP_SHL:  s = a << sh;
            OP_SHR:  s = a >> sh;
            OP_SRA:  s = sa >>> sh;
            OP_MIN:  s = (sa < sb) ? a : b;
            OP_MAX:  s = (sa > sb) ? a : b;
            OP_EQ:   s = {{(W-1){1'b0}}, (a == b)};
            OP_NE:   s = {{(W-1){1'b0}}, (a != b)};
            OP_GE:   s = {{(W-1){1'b0}}, (sa >= sb)};
            OP_GT:   s = {{(W-1){1'b0}}, (sa > sb)};
            OP_LT:   s = {{(W-1){1'b0}}, (sa < sb)};
            OP_NEG:  s = -a;
            OP_BNOT: s = ~a;
            OP_ABS:  s = a[W-1] ? -a : a;
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/alu_stack_ctrl_op_stack.sv
// DEPTH x W operand stack with a valid count; reads of top and top-1 are combinational.
// Latency: writes and count updates land on the next clk edge. Backpressure: none, caller guards bounds.
module op_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH+1),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          cnt_ld,
    input  logic [DW-1:0] cnt_nxt,
    output logic [DW-1:0] cnt,
    output logic [W-1:0]  rd_top,
    output logic [W-1:0]  rd_sec
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] top_idx;
    logic [AW-1:0] sec_idx;

    // Low address bits wrap cleanly: cnt==DEPTH maps to index DEPTH-1.
    assign top_idx = cnt[AW-1:0] - AW'(1);
    assign sec_idx = cnt[AW-1:0] - AW'(2);

    assign rd_top = (cnt >= DW'(1)) ? mem[top_idx] : '0;
    assign rd_sec = (cnt >= DW'(2)) ? mem[sec_idx] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_ld) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/alu_stack_ctrl.sv
// RPN stack sequencer: pushes/pops operands and runs OPs through an external alu, writing the result back.
// Latency: PUSH/POP/CLEAR 1 cycle; OP 3 cycles (latch, execute, writeback). Backpressure: cmd_ready low during EXEC/WB.
module alu_stack_ctrl
    import alu_stack_ctrl_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_kind,
    input  logic [W-1:0]  cmd_data,
    input  logic [4:0]    cmd_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [4:0]    alu_f,
    input  logic [W-1:0]  alu_s,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic [W-1:0]  res;
    logic [DW-1:0] wslot;
    logic          unary_q;

    logic          fire;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          cnt_ld;
    logic [DW-1:0] cnt_nxt;
    logic [W-1:0]  rd_sec;
    logic          full;
    logic          op_unary;
    logic [DW-1:0] op_need;

    assign fire     = cmd_valid && cmd_ready;
    assign full     = (depth == DW'(DEPTH));
    assign op_unary = op_is_unary(cmd_op);
    assign op_need  = op_unary ? DW'(1) : DW'(2);

    op_stack #(.W(W), .DEPTH(DEPTH), .DW(DW), .AW(AW)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cnt_ld  (cnt_ld),
        .cnt_nxt (cnt_nxt),
        .cnt     (depth),
        .rd_top  (top),
        .rd_sec  (rd_sec)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = depth[AW-1:0];
        wr_data = cmd_data;
        cnt_ld  = 1'b0;
        cnt_nxt = depth;
        if (state == ST_WB) begin
            wr_en   = 1'b1;
            wr_addr = wslot[AW-1:0];
            wr_data = res;
            cnt_ld  = 1'b1;
            cnt_nxt = unary_q ? depth : depth - DW'(1);
        end else if (fire) begin
            case (cmd_kind)
                K_PUSH: begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        cnt_ld  = 1'b1;
                        cnt_nxt = depth + DW'(1);
                    end
                end
                K_POP: begin
                    if (depth != '0) begin
                        cnt_ld  = 1'b1;
                        cnt_nxt = depth - DW'(1);
                    end
                end
                K_CLEAR: begin
                    cnt_ld  = 1'b1;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            res       <= '0;
            wslot     <= '0;
            unary_q   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        case (cmd_kind)
                            K_PUSH: begin
                                if (full) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_OVER;
                                end
                            end
                            K_POP: begin
                                if (depth == '0) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_UNDER;
                                end
                            end
                            K_OP: begin
                                // An illegal opcode is reported even when the stack is also short.
                                if (!op_is_legal(cmd_op)) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_ILL;
                                end else if (depth < op_need) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_UNDER;
                                end else begin
                                    alu_f     <= cmd_op;
                                    unary_q   <= op_unary;
                                    alu_a     <= op_unary ? top : rd_sec;
                                    alu_b     <= op_unary ? '0 : top;
                                    wslot     <= depth - op_need;
                                    cmd_ready <= 1'b0;
                                    state     <= ST_EXEC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    res   <= alu_s;
                    state <= ST_WB;
                end
                ST_WB: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Directed bench for alu_stack_ctrl wired to alu; expected values are hand-computed constants.
module tb_alu_stack_ctrl;
    import alu_stack_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [15:0] cmd_data;
    logic [4:0]  cmd_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic [15:0] alu_s;
    logic [15:0] top;
    logic [3:0]  depth;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp;
    int n_bad;

    alu_stack_ctrl #(.W(16), .DEPTH(8), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_data  (cmd_data),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_s     (alu_s),
        .top       (top),
        .depth     (depth),
        .err       (err),
        .err_code  (err_code)
    );

    alu #(.W(16)) u_alu (
        .a (alu_a),
        .b (alu_b),
        .f (alu_f),
        .s (alu_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one command on a negedge once ready, returns #1 after the accepting edge.
    task automatic send(input logic [1:0] k, input logic [15:0] d, input logic [4:0] o);
        int t;
        t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_timeout: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_kind  = k;
        cmd_data  = d;
        cmd_op    = o;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_wb();
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (depth !== 4'd0)    begin n_bad++; $display("FAIL reset_depth: got %0d want 0", depth); end
        n_cmp++; if (top !== 16'h0)     begin n_bad++; $display("FAIL reset_top: got %h want 0000", top); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (err !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b/%b want 0/00", err, err_code); end
        n_cmp++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_f !== 5'h0) begin n_bad++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_a, alu_b, alu_f); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        send(K_PUSH, 16'hFFFD, 5'h0);
        send(K_PUSH, 16'd1475, 5'h0);
        n_cmp++; if (top !== 16'd1475 || depth !== 4'd2) begin n_bad++; $display("FAIL push2: got top=%h depth=%0d want 05c3/2", top, depth); end
        send(K_OP, 16'h0, OP_ADD);
        n_cmp++; if (alu_a !== 16'hFFFD || alu_b !== 16'd1475) begin n_bad++; $display("FAIL add_exec_ops: got a=%h b=%h want fffd/05c3", alu_a, alu_b); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL add_exec_ready: got %b want 0", cmd_ready); end
        wait_wb();
        n_cmp++; if (top !== 16'd1472 || depth !== 4'd1) begin n_bad++; $display("FAIL add_result: got top=%h depth=%0d want 05c0/1", top, depth); end
        n_cmp++; if (err !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL add_after: got err=%b ready=%b want 0/1", err, cmd_ready); end
    endtask

    task automatic test_sub_mul();
        do_reset();
        send(K_PUSH, 16'hFFFD, 5'h0);
        send(K_PUSH, 16'd1475, 5'h0);
        send(K_OP, 16'h0, OP_SUB);
        wait_wb();
        n_cmp++; if (top !== 16'hFA3A || depth !== 4'd1) begin n_bad++; $display("FAIL sub_result: got top=%h depth=%0d want fa3a/1", top, depth); end
        do_reset();
        send(K_PUSH, 16'hFFFD, 5'h0);
        send(K_PUSH, 16'd1475, 5'h0);
        send(K_OP, 16'h0, OP_MUL);
        n_cmp++; if (alu_a !== 16'hFFFD || alu_b !== 16'd1475 || alu_f !== OP_MUL) begin n_bad++; $display("FAIL mul_exec: got a=%h b=%h f=%h want fffd/05c3/02", alu_a, alu_b, alu_f); end
        wait_wb();
        n_cmp++; if (top !== 16'hEEB7 || depth !== 4'd1) begin n_bad++; $display("FAIL mul_result: got top=%h depth=%0d want eeb7/1", top, depth); end
    endtask

    task automatic test_unary();
        do_reset();
        send(K_PUSH, 16'd5, 5'h0);
        send(K_OP, 16'h0, OP_NEG);
        n_cmp++; if (alu_a !== 16'd5 || alu_b !== 16'h0) begin n_bad++; $display("FAIL neg_exec: got a=%h b=%h want 0005/0000", alu_a, alu_b); end
        wait_wb();
        n_cmp++; if (top !== 16'hFFFB || depth !== 4'd1) begin n_bad++; $display("FAIL neg_result: got top=%h depth=%0d want fffb/1", top, depth); end
        do_reset();
        send(K_PUSH, 16'h0, 5'h0);
        send(K_OP, 16'h0, OP_BNOT);
        wait_wb();
        n_cmp++; if (top !== 16'hFFFF || depth !== 4'd1) begin n_bad++; $display("FAIL bnot_result: got top=%h depth=%0d want ffff/1", top, depth); end
    endtask

    task automatic test_underflow();
        do_reset();
        send(K_PUSH, 16'd9, 5'h0);
        send(K_OP, 16'h0, OP_ADD);
        n_cmp++; if (err !== 1'b1 || err_code !== ERR_UNDER) begin n_bad++; $display("FAIL under_err: got %b/%b want 1/01", err, err_code); end
        n_cmp++; if (depth !== 4'd1 || top !== 16'd9 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL under_stack: got depth=%0d top=%h ready=%b want 1/0009/1", depth, top, cmd_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (err !== 1'b0 || err_code !== ERR_UNDER) begin n_bad++; $display("FAIL under_pulse: got %b/%b want 0/01", err, err_code); end
        do_reset();
        send(K_POP, 16'h0, 5'h0);
        n_cmp++; if (err !== 1'b1 || err_code !== ERR_UNDER || depth !== 4'd0) begin n_bad++; $display("FAIL pop_empty: got %b/%b depth=%0d want 1/01/0", err, err_code, depth); end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = 16'(i + 1);
            send(K_PUSH, v, 5'h0);
        end
        n_cmp++; if (depth !== 4'd8 || top !== 16'd8 || err !== 1'b0) begin n_bad++; $display("FAIL fill: got depth=%0d top=%h err=%b want 8/0008/0", depth, top, err); end
        send(K_PUSH, 16'd100, 5'h0);
        n_cmp++; if (err !== 1'b1 || err_code !== ERR_OVER) begin n_bad++; $display("FAIL over_err: got %b/%b want 1/10", err, err_code); end
        n_cmp++; if (depth !== 4'd8 || top !== 16'd8) begin n_bad++; $display("FAIL over_stack: got depth=%0d top=%h want 8/0008", depth, top); end
        send(K_OP, 16'h0, OP_ADD);
        wait_wb();
        n_cmp++; if (depth !== 4'd7 || top !== 16'd15) begin n_bad++; $display("FAIL full_add: got depth=%0d top=%h want 7/000f", depth, top); end
    endtask

    task automatic test_illegal();
        do_reset();
        send(K_PUSH, 16'd1, 5'h0);
        send(K_PUSH, 16'd2, 5'h0);
        send(K_OP, 16'h0, 5'h13);
        n_cmp++; if (err !== 1'b1 || err_code !== ERR_ILL) begin n_bad++; $display("FAIL ill_err: got %b/%b want 1/11", err, err_code); end
        n_cmp++; if (cmd_ready !== 1'b1 || depth !== 4'd2 || top !== 16'd2) begin n_bad++; $display("FAIL ill_noexec: got ready=%b depth=%0d top=%h want 1/2/0002", cmd_ready, depth, top); end
        do_reset();
        send(K_OP, 16'h0, 5'h1F);
        n_cmp++; if (err !== 1'b1 || err_code !== ERR_ILL) begin n_bad++; $display("FAIL ill_prec: got %b/%b want 1/11", err, err_code); end
    endtask

    task automatic test_hold_valid();
        do_reset();
        send(K_PUSH, 16'd4, 5'h0);
        send(K_PUSH, 16'd6, 5'h0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind  = K_OP;
        cmd_op    = OP_ADD;
        @(posedge clk);
        #1;
        cmd_kind = K_PUSH;
        cmd_data = 16'd99;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready: got %b want 0", cmd_ready); end
        wait_wb();
        cmd_valid = 1'b0;
        n_cmp++; if (top !== 16'd10 || depth !== 4'd1) begin n_bad++; $display("FAIL hold_result: got top=%h depth=%0d want 000a/1", top, depth); end
    endtask

    task automatic test_pop_clear();
        do_reset();
        send(K_PUSH, 16'd1, 5'h0);
        send(K_PUSH, 16'd2, 5'h0);
        send(K_PUSH, 16'd3, 5'h0);
        send(K_POP, 16'h0, 5'h0);
        n_cmp++; if (depth !== 4'd2 || top !== 16'd2 || err !== 1'b0) begin n_bad++; $display("FAIL pop: got depth=%0d top=%h err=%b want 2/0002/0", depth, top, err); end
        send(K_CLEAR, 16'h0, 5'h0);
        n_cmp++; if (depth !== 4'd0 || top !== 16'h0 || err !== 1'b0) begin n_bad++; $display("FAIL clear: got depth=%0d top=%h err=%b want 0/0000/0", depth, top, err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(K_PUSH, 16'd1, 5'h0);
        send(K_PUSH, 16'd2, 5'h0);
        send(K_OP, 16'h0, OP_ADD);
        rst = 1'b1;
        #1;
        n_cmp++; if (depth !== 4'd0 || top !== 16'h0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset: got depth=%0d top=%h ready=%b want 0/0000/1", depth, top, cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(K_PUSH, 16'd7, 5'h0);
        n_cmp++; if (top !== 16'd7 || depth !== 4'd1) begin n_bad++; $display("FAIL mid_after: got top=%h depth=%0d want 0007/1", top, depth); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(K_PUSH, 16'd2, 5'h0);
        send(K_PUSH, 16'd3, 5'h0);
        send(K_PUSH, 16'd4, 5'h0);
        send(K_OP, 16'h0, OP_MUL);
        send(K_OP, 16'h0, OP_ADD);
        n_cmp++; if (alu_a !== 16'd2 || alu_b !== 16'd12) begin n_bad++; $display("FAIL b2b_exec: got a=%h b=%h want 0002/000c", alu_a, alu_b); end
        wait_wb();
        n_cmp++; if (top !== 16'd14 || depth !== 4'd1) begin n_bad++; $display("FAIL b2b_result: got top=%h depth=%0d want 000e/1", top, depth); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cmd_valid = 1'b0;
        cmd_kind  = K_PUSH;
        cmd_data  = 16'h0;
        cmd_op    = 5'h0;
        test_reset();
        test_add();
        test_sub_mul();
        test_unary();
        test_underflow();
        test_overflow();
        test_illegal();
        test_hold_valid();
        test_pop_clear();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
